ex_hazard_unit: RTL and testbench
=================================

// Module: ex_hazard_unit
// PURPOSE
//  Consumes the decoded bundle leaving the ID/EX pipeline register, plus the EX/MEM and
//  MEM/WB destinations, and drives control back upstream.
//  Outputs: stall for IF/ID, flush for ID/EX and IF/ID, and operand-forward selects for EX.
//  A small FSM stretches load-use stalls over multi-cycle memory reads.
// PARAMETERS
//  RA_W           4   register-address width (A1/A2/A3)
//  LOAD_STALL_CYC 1   bubbles inserted per load-use hazard (1..15)
//  PC_REG         15  register index never forwarded nor hazard-checked
// PORTS
//  CLK            in   1     clock, rising edge
//  RST            in   1     asynchronous reset, active-low
//  A1_D, A2_D     in   RA_W  source regs of instruction in ID
//  Use1_D, Use2_D in   1     corresponding source actually read
//  A1_E, A2_E     in   RA_W  source regs of instruction in EX
//  RF_WE_E        in   1     EX instruction writes RF
//  WBSelect_E     in   1     1 = EX instruction is a memory load
//  A3_E           in   RA_W  EX destination
//  BranchTaken_E  in   1     branch resolved taken in EX
//  RF_WE_M, A3_M  in   1/RA_W EX/MEM writeback enable / destination
//  RF_WE_W, A3_W  in   1/RA_W MEM/WB writeback enable / destination
//  StallF, StallD out  1     hold PC and IF/ID
//  FlushD         out  1     clear IF/ID
//  FlushE         out  1     synchronous clear of ID/EX (bubble)
//  ForwardA_E     out  2     00 RF, 01 WB result, 10 MEM result
//  ForwardB_E     out  2     same, for operand B
// BEHAVIOUR
//  - Reset (RST=0, async): state=IDLE, count=0; all outputs 0 while in reset.
//  - Forwarding (combinational): ForwardA_E=10 if RF_WE_M & A3_M==A1_E & A1_E!=PC_REG;
//    else 01 if RF_WE_W & A3_W==A1_E & A1_E!=PC_REG; else 00. MEM beats WB. Same for B/A2_E.
//  - lduse = RF_WE_E & WBSelect_E & A3_E!=PC_REG &
//    ((Use1_D & A1_D==A3_E) | (Use2_D & A2_D==A3_E)).
//  - FSM states IDLE, LSTALL; count is 4 bits.
//    IDLE: BranchTaken_E -> FlushD=FlushE=1, no stall; branch beats lduse, stay IDLE.
//      Else lduse -> StallF=StallD=FlushE=1 same cycle.
//      If LOAD_STALL_CYC>1, go LSTALL with count=LOAD_STALL_CYC-2; otherwise stay IDLE.
//    LSTALL: StallF=StallD=FlushE=1 unconditionally; count==0 -> IDLE, else count-1.
//      BranchTaken_E cannot occur (EX holds a bubble); if asserted, it is ignored.
//  - Stall is combinational on the detect cycle: zero latency; total bubbles = LOAD_STALL_CYC.
//  - Reset mid-LSTALL aborts the stall immediately; the next cycle after release is IDLE.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds out ports StallCnt[31:0] and FlushCnt[31:0].
//    StallCnt +1 per cycle with StallD=1; FlushCnt +1 per cycle with FlushD=1.
//    Both saturate at all-ones and reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  ex_hazard_pkg: fwd_sel_t enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10), hz_state_t {IDLE,LSTALL},
//    constant REG_PC default. No other sub-module:
//  hazard_fwd_sel (A_E, RF_WE_M, A3_M, RF_WE_W, A3_W -> fwd_sel_t), instanced for A and B.
// TESTING
//  1 A1_E=3, RF_WE_M=1, A3_M=3, RF_WE_W=1, A3_W=3 -> ForwardA_E=10 (MEM priority).
//  2 A2_E=15, RF_WE_M=1, A3_M=15 -> ForwardB_E=00 (PC never forwarded).
//  3 LOAD_STALL_CYC=1: WBSelect_E=1, RF_WE_E=1, A3_E=5, A1_D=5, Use1_D=1
//    -> one cycle StallF=StallD=FlushE=1, then all 0.
//  4 LOAD_STALL_CYC=3, same stimulus -> stall/flush high exactly 3 consecutive cycles, then IDLE.
//  5 lduse and BranchTaken_E in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
//  6 LOAD_STALL_CYC=3: drop RST during the 2nd stall cycle -> outputs 0 at once;
//    after release: IDLE, no residual stall. With HAZARD_PERF_EN: StallCnt=0.

Source files
------------

// File: rtl/ex_hazard_pkg.sv
// Shared types and constants for the EX-stage hazard unit: forward-select encoding,
// stall FSM states and the default index of the program-counter register.
package ex_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } hz_state_t;

  localparam int unsigned REG_PC = 15;

endpackage

// File: rtl/ex_hazard_unit_fwd_sel.sv
// Operand forward selector for one EX source register: the MEM stage result wins
// over the WB result, and the PC register is never forwarded.
module hazard_fwd_sel
  import ex_hazard_pkg::*;
#(
  parameter int unsigned RA_W   = 4,
  parameter int unsigned PC_REG = REG_PC
) (
  input  logic [RA_W-1:0] A_E,
  input  logic            RF_WE_M,
  input  logic [RA_W-1:0] A3_M,
  input  logic            RF_WE_W,
  input  logic [RA_W-1:0] A3_W,
  output fwd_sel_t        Fwd
);

  localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_REG);

  always_comb begin
    Fwd = FWD_RF;
    if (A_E == PC_ADDR) begin
      Fwd = FWD_RF;
    end else if (RF_WE_M && (A3_M == A_E)) begin
      Fwd = FWD_MEM;
    end else if (RF_WE_W && (A3_W == A_E)) begin
      Fwd = FWD_WB;
    end else begin
      Fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/ex_hazard_unit.sv
// EX-stage hazard unit: operand forwarding, branch flush and load-use stall stretching.
// Optional HAZARD_PERF_EN adds saturating StallCnt/FlushCnt performance counters.
module ex_hazard_unit
  import ex_hazard_pkg::*;
#(
  parameter int unsigned RA_W           = 4,
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned PC_REG         = REG_PC
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [RA_W-1:0] A1_D,
  input  logic [RA_W-1:0] A2_D,
  input  logic            Use1_D,
  input  logic            Use2_D,
  input  logic [RA_W-1:0] A1_E,
  input  logic [RA_W-1:0] A2_E,
  input  logic            RF_WE_E,
  input  logic            WBSelect_E,
  input  logic [RA_W-1:0] A3_E,
  input  logic            BranchTaken_E,
  input  logic            RF_WE_M,
  input  logic [RA_W-1:0] A3_M,
  input  logic            RF_WE_W,
  input  logic [RA_W-1:0] A3_W,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardA_E,
`ifdef HAZARD_PERF_EN
  output logic [31:0]     StallCnt,
  output logic [31:0]     FlushCnt,
`endif
  output logic [1:0]      ForwardB_E
);

  localparam logic [RA_W-1:0] PC_ADDR  = RA_W'(PC_REG);
  localparam bit              MULTI    = (LOAD_STALL_CYC > 1);
  localparam logic [3:0]      CNT_INIT = MULTI ? 4'(LOAD_STALL_CYC - 2) : 4'd0;

  fwd_sel_t  fwd_a, fwd_b;
  hz_state_t state_d, state_q;
  logic [3:0] count_d, count_q;
  logic stall, flush_d, flush_e, lduse;

  hazard_fwd_sel #(.RA_W(RA_W), .PC_REG(PC_REG)) u_fwd_a (
    .A_E(A1_E), .RF_WE_M(RF_WE_M), .A3_M(A3_M), .RF_WE_W(RF_WE_W), .A3_W(A3_W), .Fwd(fwd_a)
  );

  hazard_fwd_sel #(.RA_W(RA_W), .PC_REG(PC_REG)) u_fwd_b (
    .A_E(A2_E), .RF_WE_M(RF_WE_M), .A3_M(A3_M), .RF_WE_W(RF_WE_W), .A3_W(A3_W), .Fwd(fwd_b)
  );

  assign lduse = RF_WE_E && WBSelect_E && (A3_E != PC_ADDR) &&
                 ((Use1_D && (A1_D == A3_E)) || (Use2_D && (A2_D == A3_E)));

  // A branch outranks a load-use hazard; LSTALL ignores branches since EX holds a bubble.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    stall   = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    case (state_q)
      IDLE: begin
        if (BranchTaken_E) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lduse) begin
          stall   = 1'b1;
          flush_e = 1'b1;
          if (MULTI) begin
            state_d = LSTALL;
            count_d = CNT_INIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LSTALL: begin
        stall   = 1'b1;
        flush_e = 1'b1;
        if (count_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Outputs are zero-latency, so they are gated directly by reset.
  assign StallF     = RST & stall;
  assign StallD     = RST & stall;
  assign FlushD     = RST & flush_d;
  assign FlushE     = RST & flush_e;
  assign ForwardA_E = RST ? fwd_a : FWD_RF;
  assign ForwardB_E = RST ? fwd_b : FWD_RF;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (FlushD && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_hazard_unit.sv
// Directed bench for ex_hazard_unit: two instances (LOAD_STALL_CYC=1 and 3) share stimulus.
module tb_ex_hazard_unit;

  logic       CLK, RST;
  logic [3:0] A1_D, A2_D, A1_E, A2_E, A3_E, A3_M, A3_W;
  logic       Use1_D, Use2_D, RF_WE_E, WBSelect_E, BranchTaken_E, RF_WE_M, RF_WE_W;
  logic       sf1, sd1, fd1, fe1, sf3, sd3, fd3, fe3;
  logic [1:0] fa1, fb1, fa3, fb3;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  int errs   = 0;
  int checks = 0;

  ex_hazard_unit #(.RA_W(4), .LOAD_STALL_CYC(1), .PC_REG(15)) dut1 (
    .CLK(CLK), .RST(RST), .A1_D(A1_D), .A2_D(A2_D), .Use1_D(Use1_D), .Use2_D(Use2_D),
    .A1_E(A1_E), .A2_E(A2_E), .RF_WE_E(RF_WE_E), .WBSelect_E(WBSelect_E), .A3_E(A3_E),
    .BranchTaken_E(BranchTaken_E), .RF_WE_M(RF_WE_M), .A3_M(A3_M), .RF_WE_W(RF_WE_W),
    .A3_W(A3_W), .StallF(sf1), .StallD(sd1), .FlushD(fd1), .FlushE(fe1), .ForwardA_E(fa1),
`ifdef HAZARD_PERF_EN
    .StallCnt(sc1), .FlushCnt(fc1),
`endif
    .ForwardB_E(fb1)
  );

  ex_hazard_unit #(.RA_W(4), .LOAD_STALL_CYC(3), .PC_REG(15)) dut3 (
    .CLK(CLK), .RST(RST), .A1_D(A1_D), .A2_D(A2_D), .Use1_D(Use1_D), .Use2_D(Use2_D),
    .A1_E(A1_E), .A2_E(A2_E), .RF_WE_E(RF_WE_E), .WBSelect_E(WBSelect_E), .A3_E(A3_E),
    .BranchTaken_E(BranchTaken_E), .RF_WE_M(RF_WE_M), .A3_M(A3_M), .RF_WE_W(RF_WE_W),
    .A3_W(A3_W), .StallF(sf3), .StallD(sd3), .FlushD(fd3), .FlushE(fe3), .ForwardA_E(fa3),
`ifdef HAZARD_PERF_EN
    .StallCnt(sc3), .FlushCnt(fc3),
`endif
    .ForwardB_E(fb3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    A1_D = 4'd0; A2_D = 4'd0; Use1_D = 1'b0; Use2_D = 1'b0;
    A1_E = 4'd0; A2_E = 4'd0; A3_E = 4'd0; RF_WE_E = 1'b0; WBSelect_E = 1'b0;
    BranchTaken_E = 1'b0; RF_WE_M = 1'b0; A3_M = 4'd0; RF_WE_W = 1'b0; A3_W = 4'd0;
  endtask

  // Advance one cycle and drive inputs shortly after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_use();
    RF_WE_E = 1'b1; WBSelect_E = 1'b1; A3_E = 4'd5; A1_D = 4'd5; Use1_D = 1'b1;
  endtask

  // Packs {StallF,StallD,FlushD,FlushE} for compact checks.
  function automatic logic [31:0] ctl1();
    return {28'd0, sf1, sd1, fd1, fe1};
  endfunction
  function automatic logic [31:0] ctl3();
    return {28'd0, sf3, sd3, fd3, fe3};
  endfunction

  initial begin
    RST = 1'b0;
    clear_in();
    A1_E = 4'd3; RF_WE_M = 1'b1; A3_M = 4'd3;
    load_use();
    #3;
    check_val("rst_ctl1", ctl1(), 32'h0);
    check_val("rst_ctl3", ctl3(), 32'h0);
    check_val("rst_fwdA", {30'd0, fa1}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    clear_in();
    step();

    // Forwarding
    A1_E = 4'd3; RF_WE_M = 1'b1; A3_M = 4'd3; RF_WE_W = 1'b1; A3_W = 4'd3; #2;
    check_val("fwdA_mem_prio", {30'd0, fa1}, 32'h2);
    RF_WE_M = 1'b0; #1;
    check_val("fwdA_wb", {30'd0, fa1}, 32'h1);
    RF_WE_W = 1'b0; #1;
    check_val("fwdA_rf", {30'd0, fa1}, 32'h0);
    A1_E = 4'd15; RF_WE_M = 1'b1; A3_M = 4'd15; #1;
    check_val("fwdA_pc", {30'd0, fa1}, 32'h0);
    A2_E = 4'd15; #1;
    check_val("fwdB_pc", {30'd0, fb1}, 32'h0);
    A2_E = 4'd7; RF_WE_W = 1'b1; A3_W = 4'd7; #1;
    check_val("fwdB_wb", {30'd0, fb3}, 32'h1);
    clear_in();

    // Non-hazards: source not used, destination is PC
    step();
    load_use(); Use1_D = 1'b0; #2;
    check_val("nouse_ctl3", ctl3(), 32'h0);
    Use1_D = 1'b1; A3_E = 4'd15; A1_D = 4'd15; #1;
    check_val("pcdst_ctl3", ctl3(), 32'h0);
    clear_in();

    // Load-use via operand 2; dut1 single bubble, dut3 three bubbles
    step();
    RF_WE_E = 1'b1; WBSelect_E = 1'b1; A3_E = 4'd9; A2_D = 4'd9; Use2_D = 1'b1; #2;
    check_val("ld_c1_dut1", ctl1(), 32'hD);
    check_val("ld_c1_dut3", ctl3(), 32'hD);
    step();
    clear_in(); BranchTaken_E = 1'b1; #2;
    check_val("ld_c2_dut1", ctl1(), 32'h3);
    check_val("ld_c2_dut3_br_ignored", ctl3(), 32'hD);
    step();
    BranchTaken_E = 1'b0; #2;
    check_val("ld_c3_dut1", ctl1(), 32'h0);
    check_val("ld_c3_dut3", ctl3(), 32'hD);
    step(); #2;
    check_val("ld_c4_dut3", ctl3(), 32'h0);

    // Branch and load-use in the same cycle
    step();
    load_use(); BranchTaken_E = 1'b1; #2;
    check_val("br_lduse_dut1", ctl1(), 32'h3);
    check_val("br_lduse_dut3", ctl3(), 32'h3);
    step();
    clear_in(); #2;
    check_val("br_after_dut3", ctl3(), 32'h0);

    // Reset during the second stall cycle
    step();
    load_use(); #2;
    check_val("rs_c1_dut3", ctl3(), 32'hD);
    step();
    clear_in(); #1;
    check_val("rs_c2_dut3", ctl3(), 32'hD);
    RST = 1'b0; #1;
    check_val("rs_abort_dut3", ctl3(), 32'h0);
`ifdef HAZARD_PERF_EN
    check_val("rs_stallcnt", sc3, 32'h0);
    check_val("rs_flushcnt", fc1, 32'h0);
`endif
    @(negedge CLK);
    RST = 1'b1; #1;
    check_val("rs_rel_dut3", ctl3(), 32'h0);
    step(); #2;
    check_val("rs_post_dut3", ctl3(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
